// File: rtl/esc_seq_decoder.sv
// Terminal-input escape-sequence decoder: turns a keyboard/UART byte stream into
// editing commands (cursor, home/end/insert/delete, backspace, enter, lone ESC) or printable chars.
module esc_seq_decoder #(
  parameter int PARAM_W     = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_DIGITS  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               cmd_valid,
  output logic [3:0]         cmd_code,
  output logic [PARAM_W-1:0] cmd_param,
  output logic               char_valid,
  output logic [7:0]         char_data,
  output logic               seq_error
);

  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int DC_W  = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam int EXT_W = PARAM_W + 4;

  // The timeout fires on the idle cycle whose increment would reach TIMEOUT_CYC-1.
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 2);
  localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(MAX_DIGITS);
  localparam logic [EXT_W-1:0] ACC_MAX = EXT_W'({PARAM_W{1'b1}});

  localparam logic [7:0] B_ESC   = 8'h1B;
  localparam logic [7:0] B_LBR   = 8'h5B;
  localparam logic [7:0] B_BS    = 8'h08;
  localparam logic [7:0] B_CR    = 8'h0D;
  localparam logic [7:0] B_TILDE = 8'h7E;

  localparam logic [3:0] C_ESC    = 4'd0;
  localparam logic [3:0] C_UP     = 4'd1;
  localparam logic [3:0] C_DOWN   = 4'd2;
  localparam logic [3:0] C_RIGHT  = 4'd3;
  localparam logic [3:0] C_LEFT   = 4'd4;
  localparam logic [3:0] C_HOME   = 4'd5;
  localparam logic [3:0] C_INSERT = 4'd6;
  localparam logic [3:0] C_DELETE = 4'd7;
  localparam logic [3:0] C_END    = 4'd8;
  localparam logic [3:0] C_BS     = 4'd9;
  localparam logic [3:0] C_ENTER  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_CMD  = 2'd1,
    K_CHAR = 2'd2,
    K_ERR  = 2'd3
  } kind_t;

  typedef struct packed {
    kind_t              kind;
    logic [3:0]         code;
    logic [PARAM_W-1:0] param;
    logic [7:0]         data;
  } tok_t;

  function automatic tok_t mk_cmd(input logic [3:0] code, input logic [PARAM_W-1:0] param);
    tok_t t;
    t       = '0;
    t.kind  = K_CMD;
    t.code  = code;
    t.param = param;
    return t;
  endfunction

  function automatic tok_t mk_err();
    tok_t t;
    t      = '0;
    t.kind = K_ERR;
    return t;
  endfunction

  // What a byte produces when seen outside any sequence (ESC itself is handled by the caller).
  function automatic tok_t idle_tok(input logic [7:0] b);
    tok_t t;
    t = '0;
    if (b == B_BS) begin
      t = mk_cmd(C_BS, {PARAM_W{1'b0}});
    end else if (b == B_CR) begin
      t = mk_cmd(C_ENTER, {PARAM_W{1'b0}});
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      t.kind = K_CHAR;
      t.data = b;
    end
    return t;
  endfunction

  state_t             state_q, state_d;
  tok_t               pend_q, pend_d;
  tok_t               out_tok, tok_1, tok_2;
  logic [PARAM_W-1:0] acc_q;
  logic [DC_W-1:0]    dig_q;
  logic [TO_W-1:0]    to_q;

  logic               is_digit;
  logic               dig_full;
  logic               to_fire;
  logic [EXT_W-1:0]   acc_ext;
  logic [PARAM_W-1:0] acc_next;
  logic [PARAM_W-1:0] cur_param;

  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign dig_full  = (dig_q == DC_MAX);
  assign to_fire   = (state_q == ST_ESC) && !rx_valid && (to_q == TO_LAST);
  assign acc_ext   = ({4'b0000, acc_q} * EXT_W'(10)) + EXT_W'(rx_data[3:0]);
  assign acc_next  = (acc_ext > ACC_MAX) ? ACC_MAX[PARAM_W-1:0] : acc_ext[PARAM_W-1:0];
  assign cur_param = (acc_q == '0) ? PARAM_W'(1) : acc_q;

  // State register, together with the one-entry pending output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx_data == B_ESC) state_d = ST_ESC;
        ST_ESC: begin
          if (rx_data == B_LBR)      state_d = ST_CSI;
          else if (rx_data == B_ESC) state_d = ST_ESC;
          else                       state_d = ST_IDLE;
        end
        ST_CSI: begin
          if (is_digit)              state_d = dig_full ? ST_IDLE : ST_CSI;
          else if (rx_data == B_ESC) state_d = ST_ESC;
          else                       state_d = ST_IDLE;
        end
        default:                     state_d = ST_IDLE;
      endcase
    end else if (to_fire) begin
      state_d = ST_IDLE;
    end
  end

  // tok_1 is the byte's immediate result; tok_2 is the deferred output of a byte that ended an ESC.
  always_comb begin
    tok_1 = '0;
    tok_2 = '0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx_data != B_ESC) tok_1 = idle_tok(rx_data);
        ST_ESC: begin
          if (rx_data == B_ESC) begin
            tok_1 = mk_cmd(C_ESC, {PARAM_W{1'b0}});
          end else if (rx_data != B_LBR) begin
            tok_1 = mk_cmd(C_ESC, {PARAM_W{1'b0}});
            tok_2 = idle_tok(rx_data);
          end
        end
        ST_CSI: begin
          if (is_digit) begin
            if (dig_full) tok_1 = mk_err();
          end else begin
            case (rx_data)
              8'h41:   tok_1 = mk_cmd(C_UP, cur_param);
              8'h42:   tok_1 = mk_cmd(C_DOWN, cur_param);
              8'h43:   tok_1 = mk_cmd(C_RIGHT, cur_param);
              8'h44:   tok_1 = mk_cmd(C_LEFT, cur_param);
              B_TILDE: begin
                if (acc_q == PARAM_W'(1))      tok_1 = mk_cmd(C_HOME, {PARAM_W{1'b0}});
                else if (acc_q == PARAM_W'(2)) tok_1 = mk_cmd(C_INSERT, {PARAM_W{1'b0}});
                else if (acc_q == PARAM_W'(3)) tok_1 = mk_cmd(C_DELETE, {PARAM_W{1'b0}});
                else if (acc_q == PARAM_W'(4)) tok_1 = mk_cmd(C_END, {PARAM_W{1'b0}});
                else                           tok_1 = mk_err();
              end
              default: tok_1 = mk_err();
            endcase
          end
        end
        default: tok_1 = '0;
      endcase
    end else if (to_fire) begin
      tok_1 = mk_cmd(C_ESC, {PARAM_W{1'b0}});
    end
  end

  // A pending output always goes first; whatever this cycle produced takes its place.
  always_comb begin
    if (pend_q.kind != K_NONE) begin
      out_tok = pend_q;
      pend_d  = tok_1;
    end else begin
      out_tok = tok_1;
      pend_d  = tok_2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dig_q <= '0;
      to_q  <= '0;
    end else if (rx_valid) begin
      to_q <= '0;
      if (state_q == ST_ESC && rx_data == B_LBR) begin
        acc_q <= '0;
        dig_q <= '0;
      end else if (state_q == ST_CSI && is_digit && !dig_full) begin
        acc_q <= acc_next;
        dig_q <= dig_q + 1'b1;
      end
    end else if (state_q == ST_ESC) begin
      to_q <= to_q + 1'b1;
    end
  end

  // Registered outputs: pulses for one cycle, data fields hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      cmd_param  <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
      seq_error  <= 1'b0;
    end else begin
      cmd_valid  <= (out_tok.kind == K_CMD);
      char_valid <= (out_tok.kind == K_CHAR);
      seq_error  <= (out_tok.kind == K_ERR);
      if (out_tok.kind == K_CMD) begin
        cmd_code  <= out_tok.code;
        cmd_param <= out_tok.param;
      end
      if (out_tok.kind == K_CHAR) begin
        char_data <= out_tok.data;
      end
    end
  end

endmodule

// File: tb/tb_esc_seq_decoder.sv
// Directed bench for esc_seq_decoder: one task per scenario, hand-computed expectations.
module tb_esc_seq_decoder;

  localparam int PW = 4;
  localparam int TO = 20;
  localparam int MD = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cmd_valid;
  logic [3:0]    cmd_code;
  logic [PW-1:0] cmd_param;
  logic          char_valid;
  logic [7:0]    char_data;
  logic          seq_error;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  esc_seq_decoder #(.PARAM_W(PW), .TIMEOUT_CYC(TO), .MAX_DIGITS(MD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_param(cmd_param),
    .char_valid(char_valid), .char_data(char_data), .seq_error(seq_error)
  );

  // Drive one byte from a negedge; on return the outputs show that byte's result.
  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (cmd_code !== 4'd0) $display("FAIL reset_code: got %0d want 0", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd0) $display("FAIL reset_param: got %0d want 0", cmd_param); else n_pass++;
    n_checks++; if (char_data !== 8'h00) $display("FAIL reset_char: got %h want 00", char_data); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_left();
    drive(8'h1B);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL left_esc_quiet: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h5B);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL left_csi_quiet: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h44);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b100) $display("FAIL left_pulses: got %b want 100", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (cmd_code !== 4'd4) $display("FAIL left_code: got %0d want 4", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd1) $display("FAIL left_param: got %0d want 1", cmd_param); else n_pass++;
    idle(1);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL left_pulse_width: got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 4'd4) $display("FAIL left_code_hold: got %0d want 4", cmd_code); else n_pass++;
  endtask

  task automatic test_param();
    drive(8'h1B); drive(8'h5B); drive(8'h31); drive(8'h32); drive(8'h43);
    n_checks++; if (cmd_valid !== 1'b1) $display("FAIL right_valid: got %b want 1", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 4'd3) $display("FAIL right_code: got %0d want 3", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd12) $display("FAIL right_param: got %0d want 12", cmd_param); else n_pass++;
    drive(8'h1B); drive(8'h5B); drive(8'h33); drive(8'h7E);
    n_checks++; if (cmd_valid !== 1'b1) $display("FAIL delete_valid: got %b want 1", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 4'd7) $display("FAIL delete_code: got %0d want 7", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd0) $display("FAIL delete_param: got %0d want 0", cmd_param); else n_pass++;
    idle(2);
  endtask

  task automatic test_timeout();
    int lat;
    drive(8'h1B);
    rx_valid = 1'b0;
    lat = 1;
    while (cmd_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++; if (lat != TO) $display("FAIL timeout_latency: got %0d want %0d", lat, TO); else n_pass++;
    n_checks++; if (cmd_code !== 4'd0) $display("FAIL timeout_code: got %0d want 0", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd0) $display("FAIL timeout_param: got %0d want 0", cmd_param); else n_pass++;
    drive(8'h61);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b010) $display("FAIL timeout_char_pulses: got %b want 010", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (char_data !== 8'h61) $display("FAIL timeout_char_data: got %h want 61", char_data); else n_pass++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    drive(8'h1B);
    drive(8'h61);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b100) $display("FAIL b2b_esc_pulses: got %b want 100", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (cmd_code !== 4'd0) $display("FAIL b2b_esc_code: got %0d want 0", cmd_code); else n_pass++;
    idle(1);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b010) $display("FAIL b2b_char_pulses: got %b want 010", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (char_data !== 8'h61) $display("FAIL b2b_char_data: got %h want 61", char_data); else n_pass++;
    drive(8'h1B);
    drive(8'h62);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b100) $display("FAIL burst_esc_pulses: got %b want 100", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h0D);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b010) $display("FAIL burst_char_pulses: got %b want 010", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (char_data !== 8'h62) $display("FAIL burst_char_data: got %h want 62", char_data); else n_pass++;
    idle(1);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b100) $display("FAIL burst_enter_pulses: got %b want 100", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (cmd_code !== 4'd10) $display("FAIL burst_enter_code: got %0d want 10", cmd_code); else n_pass++;
    idle(1);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL burst_drained: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
  endtask

  task automatic test_timeout_cancel();
    drive(8'h1B);
    idle(18);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL cancel_early: got %b want 0", cmd_valid); else n_pass++;
    drive(8'h5B);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL cancel_quiet: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h41);
    n_checks++; if (cmd_valid !== 1'b1) $display("FAIL cancel_up_valid: got %b want 1", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 4'd1) $display("FAIL cancel_up_code: got %0d want 1", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd1) $display("FAIL cancel_up_param: got %0d want 1", cmd_param); else n_pass++;
    idle(1);
  endtask

  task automatic test_errors();
    drive(8'h1B); drive(8'h5B); drive(8'h39); drive(8'h39); drive(8'h39);
    n_checks++; if (seq_error !== 1'b0) $display("FAIL digits_third_ok: got %b want 0", seq_error); else n_pass++;
    drive(8'h39);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b001) $display("FAIL digits_overflow: got %b want 001", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h1B); drive(8'h5B); drive(8'h35); drive(8'h7E);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b001) $display("FAIL tilde_unsupported: got %b want 001", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h41);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b010) $display("FAIL after_err_idle: got %b want 010", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (char_data !== 8'h41) $display("FAIL after_err_char: got %h want 41", char_data); else n_pass++;
    drive(8'h1B); drive(8'h5B); drive(8'h1B);
    n_checks++; if (seq_error !== 1'b1) $display("FAIL csi_esc_error: got %b want 1", seq_error); else n_pass++;
    drive(8'h5B); drive(8'h42);
    n_checks++; if (cmd_valid !== 1'b1) $display("FAIL csi_esc_restart_valid: got %b want 1", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 4'd2) $display("FAIL csi_esc_restart_code: got %0d want 2", cmd_code); else n_pass++;
    idle(1);
  endtask

  task automatic test_saturate();
    drive(8'h1B); drive(8'h5B); drive(8'h39); drive(8'h39); drive(8'h41);
    n_checks++; if (cmd_code !== 4'd1) $display("FAIL sat_code: got %0d want 1", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd15) $display("FAIL sat_param: got %0d want 15", cmd_param); else n_pass++;
    drive(8'h1B); drive(8'h5B); drive(8'h30); drive(8'h41);
    n_checks++; if (cmd_param !== 4'd1) $display("FAIL zero_param: got %0d want 1", cmd_param); else n_pass++;
    drive(8'h1B); drive(8'h5B); drive(8'h32); drive(8'h7E);
    n_checks++; if (cmd_code !== 4'd6) $display("FAIL insert_code: got %0d want 6", cmd_code); else n_pass++;
    n_checks++; if (cmd_param !== 4'd0) $display("FAIL insert_param: got %0d want 0", cmd_param); else n_pass++;
    idle(1);
  endtask

  task automatic test_idle_bytes();
    drive(8'h08);
    n_checks++; if (cmd_valid !== 1'b1) $display("FAIL bs_valid: got %b want 1", cmd_valid); else n_pass++;
    n_checks++; if (cmd_code !== 4'd9) $display("FAIL bs_code: got %0d want 9", cmd_code); else n_pass++;
    drive(8'h01);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL drop_01: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h7F);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL drop_7f: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    drive(8'h20);
    n_checks++; if (char_valid !== 1'b1) $display("FAIL space_valid: got %b want 1", char_valid); else n_pass++;
    n_checks++; if (char_data !== 8'h20) $display("FAIL space_data: got %h want 20", char_data); else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_mid();
    drive(8'h1B);
    drive(8'h5B);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b000) $display("FAIL midrst_pulses: got %b want 000", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (cmd_code !== 4'd0) $display("FAIL midrst_code: got %0d want 0", cmd_code); else n_pass++;
    n_checks++; if (char_data !== 8'h00) $display("FAIL midrst_char: got %h want 00", char_data); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(8'h44);
    n_checks++; if ({cmd_valid, char_valid, seq_error} !== 3'b010) $display("FAIL midrst_after_pulses: got %b want 010", {cmd_valid, char_valid, seq_error}); else n_pass++;
    n_checks++; if (char_data !== 8'h44) $display("FAIL midrst_after_char: got %h want 44", char_data); else n_pass++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_left();
    test_param();
    test_timeout();
    test_back_to_back();
    test_timeout_cancel();
    test_errors();
    test_saturate();
    test_idle_bytes();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
